// File: rtl/wb_bram_target.sv
// Wishbone target bridging one interconnect slot to a synchronous block RAM with registered RAM pins.
// Latency T0->ack: write 2, read 2+READ_LATENCY, range error 1; one access at a time, cyc low aborts.
module wb_bram_target #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int BRAM_ADR_WIDTH = 22,
  parameter int DEPTH_WORDS    = 2**BRAM_ADR_WIDTH,
  parameter int READ_LATENCY   = 1,
  parameter int ERR_ENABLE     = 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [ADDR_WIDTH-1:0]     adr,
  input  logic [DATA_WIDTH-1:0]     dat_w,
  output logic [DATA_WIDTH-1:0]     dat_r,
  input  logic                      cyc,
  input  logic                      stb,
  input  logic                      we,
  input  logic [DATA_WIDTH/8-1:0]   sel,
  output logic                      ack,
  output logic                      err,
  output logic [BRAM_ADR_WIDTH-1:0] bram_adr,
  output logic                      bram_en,
  output logic [DATA_WIDTH/8-1:0]   bram_we,
  output logic [DATA_WIDTH-1:0]     bram_dat_w,
  input  logic [DATA_WIDTH-1:0]     bram_dat_r
);

  localparam int SEL_WIDTH = DATA_WIDTH / 8;
  localparam int OFS       = $clog2(SEL_WIDTH);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t                   state, state_nxt;
  logic [2:0]               cnt, cnt_nxt;
  logic                     req_we;
  logic                     ack_nxt, err_nxt, en_nxt, capture;
  logic [SEL_WIDTH-1:0]     we_nxt;
  logic [BRAM_ADR_WIDTH-1:0] idx;
  logic                     in_range;
  logic                     unused_adr;

  assign idx        = adr[OFS +: BRAM_ADR_WIDTH];
  assign in_range   = ({{(64-BRAM_ADR_WIDTH){1'b0}}, idx} < 64'(DEPTH_WORDS));
  assign unused_adr = ^adr;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic also produces the next values of the registered outputs.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ack_nxt   = 1'b0;
    err_nxt   = 1'b0;
    en_nxt    = 1'b0;
    we_nxt    = '0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (cyc && stb) begin
          if (!in_range && (ERR_ENABLE != 0)) begin
            state_nxt = RESP;
            err_nxt   = 1'b1;
          end else begin
            state_nxt = ISSUE;
            en_nxt    = 1'b1;
            we_nxt    = we ? sel : '0;
          end
        end
      end
      ISSUE: begin
        if (!cyc) begin
          state_nxt = IDLE;
        end else if (req_we) begin
          state_nxt = RESP;
          ack_nxt   = 1'b1;
        end else begin
          state_nxt = WAIT;
          cnt_nxt   = 3'(READ_LATENCY);
        end
      end
      WAIT: begin
        if (!cyc) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == 3'd1) begin
          state_nxt = RESP;
          ack_nxt   = 1'b1;
          capture   = 1'b1;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt   = cnt - 3'd1;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // RAM pins only load when an access is actually issued, so rejected requests leave them quiet.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt        <= '0;
      req_we     <= 1'b0;
      ack        <= 1'b0;
      err        <= 1'b0;
      bram_en    <= 1'b0;
      bram_we    <= '0;
      bram_adr   <= '0;
      bram_dat_w <= '0;
      dat_r      <= '0;
    end else begin
      cnt     <= cnt_nxt;
      ack     <= ack_nxt;
      err     <= err_nxt;
      bram_en <= en_nxt;
      bram_we <= we_nxt;
      if (en_nxt) begin
        bram_adr   <= idx;
        bram_dat_w <= dat_w;
        req_we     <= we;
      end
      if (capture) dat_r <= bram_dat_r;
    end
  end

endmodule

// File: tb/tb_wb_bram_target.sv
// Directed bench: three targets (RL=1 err, RL=3 err, RL=1 wrap) each with its own pipelined RAM model.
module tb_wb_bram_target;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] adr;
  logic [31:0] dat_w;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [2:0]  cyc;
  logic [2:0]  ack;
  logic [2:0]  err;
  logic [2:0]  bram_en;
  logic [31:0] dat_r      [3];
  logic [9:0]  bram_adr   [3];
  logic [3:0]  bram_we    [3];
  logic [31:0] bram_dat_w [3];
  logic [31:0] bram_dat_r [3];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int RL = (g == 1) ? 3 : 1;
    logic [31:0] mem [1024];
    logic [31:0] pd  [4];
    logic [3:0]  pv;

    wb_bram_target #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .BRAM_ADR_WIDTH(10), .DEPTH_WORDS(256),
      .READ_LATENCY(RL), .ERR_ENABLE((g == 2) ? 0 : 1)
    ) u_dut (
      .clock(clock), .reset(reset), .adr(adr), .dat_w(dat_w), .dat_r(dat_r[g]),
      .cyc(cyc[g]), .stb(stb), .we(we), .sel(sel), .ack(ack[g]), .err(err[g]),
      .bram_adr(bram_adr[g]), .bram_en(bram_en[g]), .bram_we(bram_we[g]),
      .bram_dat_w(bram_dat_w[g]), .bram_dat_r(bram_dat_r[g])
    );

    // Read data is only valid exactly RL cycles after the enable edge; poison otherwise.
    always @(posedge clock) begin
      if (bram_en[g])
        for (int b = 0; b < 4; b++)
          if (bram_we[g][b]) mem[bram_adr[g]][8*b +: 8] <= bram_dat_w[g][8*b +: 8];
      pv    <= reset ? 4'b0 : {pv[2:0], bram_en[g] && (bram_we[g] == 4'b0)};
      pd[0] <= mem[bram_adr[g]];
      for (int k = 1; k < 4; k++) pd[k] <= pd[k-1];
    end
    assign bram_dat_r[g] = pv[RL-1] ? pd[RL-1] : 32'hDEAD_BEEF;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One complete access on target i, checking every cycle from T0 to one cycle past the response.
  task automatic xfer(input int i, input bit w, input logic [31:0] a, input logic [3:0] s,
                      input logic [31:0] d, input bit is_err, input logic [31:0] exp_dat);
    int resp;
    resp  = is_err ? 1 : (w ? 2 : 2 + ((i == 1) ? 3 : 1));
    adr   = a;
    we    = w;
    sel   = s;
    dat_w = d;
    stb   = 1'b1;
    cyc[i] = 1'b1;
    chk($sformatf("i%0d_t0_ack", i), ack[i], 1'b0);
    for (int c = 1; c <= resp; c++) begin
      tick();
      chk($sformatf("i%0d_a%0h_c%0d_en", i, a, c), bram_en[i], (c == 1) && !is_err);
      chk($sformatf("i%0d_a%0h_c%0d_ack", i, a, c), ack[i], (c == resp) && !is_err);
      chk($sformatf("i%0d_a%0h_c%0d_err", i, a, c), err[i], (c == resp) && is_err);
      if (c == 1 && !is_err) begin
        chk($sformatf("i%0d_a%0h_badr", i, a), bram_adr[i], a[2 +: 10]);
        chk($sformatf("i%0d_a%0h_bwe", i, a), bram_we[i], w ? s : 4'b0);
        if (w) chk($sformatf("i%0d_a%0h_bdatw", i, a), bram_dat_w[i], d);
      end
    end
    chk($sformatf("i%0d_a%0h_datr", i, a), dat_r[i], exp_dat);
    stb    = 1'b0;
    we     = 1'b0;
    cyc[i] = 1'b0;
    tick();
    chk($sformatf("i%0d_a%0h_post_resp", i, a), {ack[i], err[i], bram_en[i]}, 3'b000);
    chk($sformatf("i%0d_a%0h_post_datr", i, a), dat_r[i], exp_dat);
  endtask

  initial begin
    reset = 1'b1;
    cyc   = 3'b000;
    stb   = 1'b0;
    we    = 1'b0;
    sel   = 4'h0;
    adr   = 32'h0;
    dat_w = 32'h0;
    repeat (2) @(posedge clock);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_ctl_%0d", i), {ack[i], err[i], bram_en[i], bram_we[i]}, 7'b0);
      chk($sformatf("rst_dat_%0d", i), {dat_r[i], bram_dat_w[i], bram_adr[i]}, 74'b0);
    end
    reset = 1'b0;
    tick();

    // RL=1 target: byte-lane writes, full writes, sel=0 write, reads and out-of-range error.
    xfer(0, 1'b1, 32'h10, 4'hF, 32'h1122_3344, 1'b0, 32'h0);
    xfer(0, 1'b1, 32'h10, 4'b0110, 32'hAABB_CCDD, 1'b0, 32'h0);
    xfer(0, 1'b0, 32'h10, 4'hF, 32'h0, 1'b0, 32'h11BB_CC44);
    xfer(0, 1'b1, 32'h10, 4'hF, 32'h1234_5678, 1'b0, 32'h11BB_CC44);
    xfer(0, 1'b0, 32'h10, 4'hF, 32'h0, 1'b0, 32'h1234_5678);
    xfer(0, 1'b1, 32'h10, 4'h0, 32'hFFFF_FFFF, 1'b0, 32'h1234_5678);
    xfer(0, 1'b0, 32'h13, 4'hF, 32'h0, 1'b0, 32'h1234_5678);
    xfer(0, 1'b0, 32'h400, 4'hF, 32'h0, 1'b1, 32'h1234_5678);

    // Wrapping target: the same out-of-range index acks and reaches the RAM.
    xfer(2, 1'b1, 32'h400, 4'hF, 32'hCAFE_F00D, 1'b0, 32'h0);
    xfer(2, 1'b0, 32'h400, 4'hF, 32'h0, 1'b0, 32'hCAFE_F00D);

    // RL=3 target.
    xfer(1, 1'b1, 32'h20, 4'hF, 32'h5566_7788, 1'b0, 32'h0);
    xfer(1, 1'b0, 32'h20, 4'hF, 32'h0, 1'b0, 32'h5566_7788);
    xfer(1, 1'b1, 32'h0, 4'hF, 32'hA5A5_A5A5, 1'b0, 32'h5566_7788);

    // Abort a read in its second WAIT cycle.
    adr = 32'h0; we = 1'b0; sel = 4'hF; stb = 1'b1; cyc[1] = 1'b1;
    tick();
    chk("abort_issue_en", bram_en[1], 1'b1);
    tick();
    tick();
    cyc[1] = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk($sformatf("abort_resp_c%0d", c), {ack[1], err[1], bram_en[1]}, 3'b000);
      chk($sformatf("abort_datr_c%0d", c), dat_r[1], 32'h5566_7788);
    end
    stb = 1'b0;
    xfer(1, 1'b0, 32'h0, 4'hF, 32'h0, 1'b0, 32'hA5A5_A5A5);

    // Reset asserted while waiting on the RAM.
    adr = 32'h20; we = 1'b0; sel = 4'hF; stb = 1'b1; cyc[1] = 1'b1;
    tick();
    tick();
    chk("pre_rst_datr", dat_r[1], 32'hA5A5_A5A5);
    #2 reset = 1'b1;
    #1;
    chk("midrst_ctl", {ack[1], err[1], bram_en[1], bram_we[1]}, 7'b0);
    chk("midrst_datr1", dat_r[1], 32'h0);
    chk("midrst_datr0", dat_r[0], 32'h0);
    cyc[1] = 1'b0;
    stb    = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    xfer(1, 1'b1, 32'h1C, 4'hF, 32'h7E57_0007, 1'b0, 32'h0);
    xfer(1, 1'b0, 32'h1C, 4'hF, 32'h0, 1'b0, 32'h7E57_0007);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
